// File: rtl/fft_sequencer.sv
// fft_sequencer
//
// Top-level job sequencer for an in-place radix-2 FFT engine. One job runs
// through four phases: samples are loaded into SRAM bank 0 in bit-reversed
// order, the butterfly datapath is enabled until it reports completion, and
// the result is streamed out of the stage-parity bank in natural order.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no job; stage control held in reset; waits for i_start
// LOAD   | accepts N samples, writes bank 0 at bit-reversed addresses
// RUN    | butterfly datapath enabled until i_fft_done
// UNLOAD | reads result bank 0..N-1 through a 2-entry output FIFO
//
// Ports
//   clk, i_reset            single clock, synchronous active-high reset
//   i_start                 begin a job (IDLE only, not on the o_done cycle)
//   i_point_configuration   size code, N = 8 << code
//   o_point_configuration   code latched at job start
//   o_pc_resetn             active-low reset to the stage-control block
//   o_working               butterfly datapath enable
//   i_fft_done              all stages complete (RUN only)
//   i_in_*/o_in_ready       sample load handshake
//   o_wr_*                  SRAM write port
//   o_rd_*/i_rd_data        SRAM read port, data one cycle after o_rd_en
//   o_out_*/i_out_ready     result unload handshake
//   o_busy, o_done          job status, o_done is a 1-cycle pulse

module fft_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_point_configuration,
  output logic [2:0]        o_point_configuration,
  output logic              o_pc_resetn,
  output logic              o_working,
  input  logic              i_fft_done,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic              o_wr_bank,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_en,
  output logic              o_rd_bank,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  // One extra bit so a count can reach N itself without wrapping.
  localparam int CW = ADDR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  logic [1:0]        state_q;
  logic [2:0]        cfg_q;
  logic [3:0]        lvl_q;
  logic [CW-1:0]     n_pts_q;
  logic [CW-1:0]     ld_cnt_q;
  logic [CW-1:0]     rd_cnt_q;
  logic              working_q;
  logic              done_q;

  logic              rd_inflight_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              fifo_wp_q;
  logic              fifo_rp_q;
  logic [1:0]        fifo_cnt_q;

  logic [3:0]        lvl_nxt;
  logic              start_ok;
  logic              in_ready;
  logic              ld_hs;
  logic              ld_last;
  logic [ADDR_W-1:0] cnt_rev;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_valid;
  logic              head_last;
  logic              pop;
  logic              push;
  logic [1:0]        occ_after_pop;
  logic [1:0]        slots_used;
  logic              rd_issue;
  logic              unload_end;

  assign lvl_nxt  = {1'b0, i_point_configuration} + 4'd3;

  // A start coincident with the done pulse belongs to the job just finished.
  assign start_ok = (state_q == S_IDLE) && i_start && !done_q;

  assign in_ready = (state_q == S_LOAD) && !i_reset;
  assign ld_hs    = in_ready && i_in_valid;
  assign ld_last  = ld_hs && (ld_cnt_q == n_pts_q - CW'(1));

  // Bit-reverse the whole ADDR_W field, then shift down so only the low L
  // bits of the count take part in the reversal.
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      cnt_rev[i] = ld_cnt_q[ADDR_W-1-i];
    end
  end

  assign wr_addr = cnt_rev >> (ADDR_W - int'(lvl_q));

  assign out_valid = (fifo_cnt_q != 2'd0) && !i_reset;
  assign head_last = fifo_last_q[fifo_rp_q];
  assign pop       = out_valid && i_out_ready;
  assign push      = rd_inflight_q;

  // Counting the slot freed by this cycle's pop keeps a read issuing every
  // cycle while the consumer is ready, without ever overfilling the FIFO.
  assign occ_after_pop = fifo_cnt_q - {1'b0, pop};
  assign slots_used    = occ_after_pop + {1'b0, rd_inflight_q};
  assign rd_issue      = (state_q == S_UNLOAD) && (rd_cnt_q < n_pts_q) &&
                         (slots_used < 2'd2) && !i_reset;

  assign unload_end = (state_q == S_UNLOAD) && pop && head_last;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      cfg_q         <= '0;
      lvl_q         <= '0;
      n_pts_q       <= '0;
      ld_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      working_q     <= 1'b0;
      done_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      fifo_last_q   <= '0;
      fifo_wp_q     <= 1'b0;
      fifo_rp_q     <= 1'b0;
      fifo_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q  <= S_LOAD;
            cfg_q    <= i_point_configuration;
            lvl_q    <= lvl_nxt;
            n_pts_q  <= {{(CW-1){1'b0}}, 1'b1} << lvl_nxt;
            ld_cnt_q <= '0;
            rd_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          if (ld_hs) begin
            ld_cnt_q <= ld_cnt_q + CW'(1);
            if (ld_last) begin
              state_q   <= S_RUN;
              working_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_fft_done) begin
            state_q   <= S_UNLOAD;
            working_q <= 1'b0;
          end
        end
        S_UNLOAD: begin
          if (unload_end) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      done_q <= unload_end;

      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
      end
      rd_inflight_q <= rd_issue;
      rd_last_q     <= rd_issue && (rd_cnt_q == n_pts_q - CW'(1));

      if (push) begin
        fifo_data_q[fifo_wp_q] <= i_rd_data;
        fifo_last_q[fifo_wp_q] <= rd_last_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) begin
        fifo_rp_q <= ~fifo_rp_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign o_point_configuration = cfg_q;
  assign o_pc_resetn           = (state_q != S_IDLE) && !i_reset;
  assign o_busy                = (state_q != S_IDLE) && !i_reset;
  assign o_working             = working_q;
  assign o_done                = done_q;

  assign o_in_ready = in_ready;
  assign o_wr_en    = ld_hs;
  assign o_wr_bank  = 1'b0;
  assign o_wr_addr  = wr_addr;
  assign o_wr_data  = i_in_data;

  // The FFT leaves its result in the bank selected by the stage count parity.
  assign o_rd_en   = rd_issue;
  assign o_rd_bank = lvl_q[0];
  assign o_rd_addr = rd_cnt_q[ADDR_W-1:0];

  assign o_out_valid = out_valid;
  assign o_out_data  = fifo_data_q[fifo_rp_q];
  assign o_out_last  = out_valid && head_last;

endmodule
